// File: rtl/countdown_ctrl_if.sv
// ============================================================================
// Module   : countdown_ctrl_if
// Brief    : Front-panel bus between board buttons / datapath and countdown_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface countdown_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_start;
  logic        finish;
  logic [31:0] preset;
  logic        go;
  logic [2:0]  cursor;
  logic        blink;
  logic        alarm;

  // Board / datapath side: drives raw buttons and finish, observes controls.
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_start, finish,
    input  preset, go, cursor, blink, alarm
  );

  // Sequencer side.
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_start, finish,
    output preset, go, cursor, blink, alarm
  );
endinterface

`default_nettype wire

// File: rtl/countdown_ctrl.sv
// ============================================================================
// Module   : countdown_ctrl
// Brief    : Button debounce, BCD preset editor, run control and timed alarm
//            for the countdown timer datapath.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module countdown_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned BLINK_CYC    = 25_000_000,
  parameter int unsigned ALARM_CYC    = 500_000_000,
  parameter logic [31:0] PRESET_INIT  = 32'h00F01F00
) (
  input wire              clk,
  input wire              rst,
  countdown_ctrl_if.slave bus
);

  localparam int unsigned c_db_w    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned c_blink_w = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned c_alarm_w = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;

  localparam logic [c_db_w-1:0]    c_db_last    = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_CYC - 1);
  localparam logic [c_alarm_w-1:0] c_alarm_last = c_alarm_w'(ALARM_CYC - 1);

  localparam logic [31:0] c_preset_zero = 32'h00F00F00;

  // Button vector order doubles as event priority: higher index wins.
  localparam int c_b_right = 0;
  localparam int c_b_left  = 1;
  localparam int c_b_down  = 2;
  localparam int c_b_up    = 3;
  localparam int c_b_start = 4;

  typedef enum logic [1:0] {
    S_EDIT  = 2'd0,
    S_RUN   = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [4:0] w_btn_raw;
  logic [4:0] r_btn_s1;
  logic [4:0] r_btn_s2;
  logic       r_fin_s1;
  logic       r_fin_s2;
  logic [4:0] w_event;

  logic [31:0]          r_preset;
  logic [31:0]          w_preset_nxt;
  logic [2:0]           r_cursor;
  logic [2:0]           w_cursor_nxt;
  logic                 r_blink;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 w_blink_clr;
  logic [c_alarm_w-1:0] r_alarm_cnt;

  logic       w_ev_start;
  logic       w_ev_up;
  logic       w_ev_down;
  logic       w_ev_left;
  logic       w_ev_right;
  logic       w_ev_any;
  logic [2:0] w_pos;
  logic [3:0] w_dmax;
  logic [3:0] w_digit;
  logic [3:0] w_digit_nxt;
  logic       w_go;
  logic       w_alarm;

  assign w_btn_raw = {bus.btn_start, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_fin_s1 <= 1'b0;
      r_fin_s2 <= 1'b0;
    end else begin
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_fin_s1 <= bus.finish;
      r_fin_s2 <= r_fin_s1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYC consecutive samples that
  // differ from the current accepted level; only rising acceptances pulse.
  for (genvar gi = 0; gi < 5; gi++) begin : g_debounce
    logic [c_db_w-1:0] r_cnt;
    logic              r_level;
    logic              r_event;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_event <= 1'b0;
      end else begin
        r_event <= 1'b0;
        if (r_btn_s2[gi] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_last) begin
          r_cnt   <= '0;
          r_level <= r_btn_s2[gi];
          r_event <= r_btn_s2[gi];
        end else begin
          r_cnt <= r_cnt + c_db_w'(1);
        end
      end
    end

    assign w_event[gi] = r_event;
  end

  assign w_ev_start = w_event[c_b_start];
  assign w_ev_up    = w_event[c_b_up]    & ~w_event[c_b_start];
  assign w_ev_down  = w_event[c_b_down]  & ~(|w_event[c_b_start:c_b_up]);
  assign w_ev_left  = w_event[c_b_left]  & ~(|w_event[c_b_start:c_b_down]);
  assign w_ev_right = w_event[c_b_right] & ~(|w_event[c_b_start:c_b_left]);
  assign w_ev_any   = |w_event;

  // Cursor to nibble position; nibbles 2 and 5 are the 4'hF fillers.
  always_comb begin
    w_pos  = 3'd0;
    w_dmax = 4'd9;
    case (r_cursor)
      3'd0:    w_pos = 3'd0;
      3'd1:    begin w_pos = 3'd1; w_dmax = 4'd5; end
      3'd2:    w_pos = 3'd3;
      3'd3:    begin w_pos = 3'd4; w_dmax = 4'd5; end
      3'd4:    w_pos = 3'd6;
      3'd5:    w_pos = 3'd7;
      default: w_pos = 3'd0;
    endcase
  end

  assign w_digit = r_preset[{w_pos, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EDIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_preset_nxt = r_preset;
    w_cursor_nxt = r_cursor;
    w_digit_nxt  = w_digit;
    w_blink_clr  = 1'b0;
    w_go         = 1'b0;
    w_alarm      = 1'b0;
    case (r_state)
      S_EDIT: begin
        if (w_ev_start) begin
          if (r_preset != c_preset_zero) begin
            w_state_nxt = S_RUN;
          end
        end else if (w_ev_up) begin
          w_digit_nxt = (w_digit == w_dmax) ? 4'd0 : w_digit + 4'd1;
          w_preset_nxt[{w_pos, 2'b00} +: 4] = w_digit_nxt;
          w_blink_clr = 1'b1;
        end else if (w_ev_down) begin
          w_digit_nxt = (w_digit == 4'd0) ? w_dmax : w_digit - 4'd1;
          w_preset_nxt[{w_pos, 2'b00} +: 4] = w_digit_nxt;
          w_blink_clr = 1'b1;
        end else if (w_ev_left) begin
          w_cursor_nxt = (r_cursor == 3'd5) ? 3'd0 : r_cursor + 3'd1;
          w_blink_clr  = 1'b1;
        end else if (w_ev_right) begin
          w_cursor_nxt = (r_cursor == 3'd0) ? 3'd5 : r_cursor - 3'd1;
          w_blink_clr  = 1'b1;
        end
      end
      S_RUN: begin
        w_go = 1'b1;
        if (r_fin_s2) begin
          w_state_nxt = S_ALARM;
        end else if (w_ev_start) begin
          w_state_nxt = S_EDIT;
        end
      end
      S_ALARM: begin
        w_alarm = 1'b1;
        if (w_ev_any || (r_alarm_cnt == c_alarm_last)) begin
          w_state_nxt = S_EDIT;
        end
      end
      default: w_state_nxt = S_EDIT;
    endcase
    if ((w_state_nxt == S_EDIT) && (r_state != S_EDIT)) begin
      w_blink_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_preset <= PRESET_INIT;
      r_cursor <= 3'd0;
    end else begin
      r_preset <= w_preset_nxt;
      r_cursor <= w_cursor_nxt;
    end
  end

  // Cleared as soon as EDIT is left so blink is already 0 in the first RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_blink_clr || (w_state_nxt != S_EDIT)) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == c_blink_last) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm_cnt <= '0;
    end else if ((r_state == S_ALARM) && (w_state_nxt == S_ALARM)) begin
      r_alarm_cnt <= r_alarm_cnt + c_alarm_w'(1);
    end else begin
      r_alarm_cnt <= '0;
    end
  end

  assign bus.preset = r_preset;
  assign bus.go     = w_go;
  assign bus.cursor = r_cursor;
  assign bus.blink  = r_blink;
  assign bus.alarm  = w_alarm;

endmodule

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// ============================================================================
// Module   : tb_countdown_ctrl
// Brief    : Directed self-checking bench for countdown_ctrl (small timing params).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_countdown_ctrl;

  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_START = 4;

  logic       clk;
  logic       rst;
  logic [4:0] tb_btn;
  logic       tb_finish;
  int         checks;
  int         failures;

  countdown_ctrl_if bus ();

  assign bus.btn_right = tb_btn[B_RIGHT];
  assign bus.btn_left  = tb_btn[B_LEFT];
  assign bus.btn_down  = tb_btn[B_DOWN];
  assign bus.btn_up    = tb_btn[B_UP];
  assign bus.btn_start = tb_btn[B_START];
  assign bus.finish    = tb_finish;

  countdown_ctrl #(
    .DEBOUNCE_CYC (4),
    .BLINK_CYC    (8),
    .ALARM_CYC    (20),
    .PRESET_INIT  (32'h00F01F00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: called on a negedge, holds the buttons, then lets the release settle.
  task automatic press_mask(input logic [4:0] mask, input int hold);
    tb_btn = mask;
    repeat (hold) @(negedge clk);
    tb_btn = 5'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic press(input int idx);
    logic [4:0] m;
    m = 5'b0;
    m[idx] = 1'b1;
    press_mask(m, 10);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.preset !== 32'h00F01F00) begin failures++; $display("FAIL reset_preset: got %h expected %h", bus.preset, 32'h00F01F00); end
    checks++;
    if ({bus.go, bus.cursor, bus.blink, bus.alarm} !== 6'b0) begin
      failures++; $display("FAIL reset_outputs: go=%b cursor=%0d blink=%b alarm=%b expected all 0", bus.go, bus.cursor, bus.blink, bus.alarm);
    end
    rst = 1'b0;
  endtask

  task automatic test_blink;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.blink !== 1'b0) begin failures++; $display("FAIL blink_before_toggle: got %b expected 0", bus.blink); end
    @(negedge clk);
    checks++;
    if (bus.blink !== 1'b1) begin failures++; $display("FAIL blink_first_toggle: got %b expected 1", bus.blink); end
    repeat (8) @(negedge clk);
    checks++;
    if (bus.blink !== 1'b0) begin failures++; $display("FAIL blink_second_toggle: got %b expected 0", bus.blink); end
  endtask

  task automatic test_debounce;
    press(B_UP);
    checks++;
    if (bus.preset !== 32'h00F01F01) begin failures++; $display("FAIL debounce_hold_one_event: got %h expected %h", bus.preset, 32'h00F01F01); end
    press_mask(5'b01000, 3);
    checks++;
    if (bus.preset !== 32'h00F01F01) begin failures++; $display("FAIL debounce_bounce_ignored: got %h expected %h", bus.preset, 32'h00F01F01); end
  endtask

  task automatic test_edit_cursor;
    press(B_LEFT);
    checks++;
    if (bus.cursor !== 3'd1) begin failures++; $display("FAIL cursor_left: got %0d expected 1", bus.cursor); end
    press(B_DOWN);
    checks++;
    if (bus.preset !== 32'h00F01F51) begin failures++; $display("FAIL s10_down_wrap: got %h expected %h", bus.preset, 32'h00F01F51); end
    press(B_UP);
    checks++;
    if (bus.preset !== 32'h00F01F01) begin failures++; $display("FAIL s10_up_wrap: got %h expected %h", bus.preset, 32'h00F01F01); end
    press(B_DOWN);
    checks++;
    if (bus.preset !== 32'h00F01F51) begin failures++; $display("FAIL s10_down_again: got %h expected %h", bus.preset, 32'h00F01F51); end
    for (int i = 0; i < 4; i++) press(B_LEFT);
    checks++;
    if (bus.cursor !== 3'd5) begin failures++; $display("FAIL cursor_to_h10: got %0d expected 5", bus.cursor); end
    press(B_LEFT);
    checks++;
    if (bus.cursor !== 3'd0) begin failures++; $display("FAIL cursor_left_wrap: got %0d expected 0", bus.cursor); end
    press(B_RIGHT);
    checks++;
    if (bus.cursor !== 3'd5) begin failures++; $display("FAIL cursor_right_wrap: got %0d expected 5", bus.cursor); end
    press(B_DOWN);
    checks++;
    if (bus.preset !== 32'h90F01F51) begin failures++; $display("FAIL h10_down_wrap: got %h expected %h", bus.preset, 32'h90F01F51); end
    press(B_UP);
    checks++;
    if (bus.preset !== 32'h00F01F51) begin failures++; $display("FAIL h10_up_wrap: got %h expected %h", bus.preset, 32'h00F01F51); end
  endtask

  task automatic test_start_zero;
    press(B_RIGHT); press(B_RIGHT); press(B_RIGHT);
    press(B_DOWN);
    press(B_RIGHT);
    press(B_UP);
    press(B_RIGHT);
    press(B_DOWN);
    checks++;
    if (bus.preset !== 32'h00F00F00) begin failures++; $display("FAIL zero_preset_setup: got %h expected %h", bus.preset, 32'h00F00F00); end
    press(B_START);
    checks++;
    if (bus.go !== 1'b0) begin failures++; $display("FAIL start_on_zero_ignored: go=%b expected 0", bus.go); end
    for (int i = 0; i < 5; i++) press(B_UP);
    checks++;
    if (bus.preset !== 32'h00F00F05) begin failures++; $display("FAIL s1_up_to_5: got %h expected %h", bus.preset, 32'h00F00F05); end
    tb_btn[B_START] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.go !== 1'b0) begin failures++; $display("FAIL start_latency_early: go=%b expected 0", bus.go); end
    @(negedge clk);
    checks++;
    if (bus.go !== 1'b1) begin failures++; $display("FAIL start_latency_go: go=%b expected 1", bus.go); end
    checks++;
    if (bus.blink !== 1'b0) begin failures++; $display("FAIL run_blink_off: got %b expected 0", bus.blink); end
    repeat (3) @(negedge clk);
    tb_btn = 5'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_finish_alarm;
    tb_finish = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.go, bus.alarm} !== 2'b10) begin failures++; $display("FAIL finish_sync_delay: go=%b alarm=%b expected go=1 alarm=0", bus.go, bus.alarm); end
    @(negedge clk);
    checks++;
    if ({bus.go, bus.alarm} !== 2'b01) begin failures++; $display("FAIL finish_to_alarm: go=%b alarm=%b expected go=0 alarm=1", bus.go, bus.alarm); end
    tb_finish = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if (bus.alarm !== 1'b1) begin failures++; $display("FAIL alarm_last_cycle: got %b expected 1", bus.alarm); end
    @(negedge clk);
    checks++;
    if ({bus.go, bus.alarm} !== 2'b00) begin failures++; $display("FAIL alarm_timeout: go=%b alarm=%b expected both 0", bus.go, bus.alarm); end
    checks++;
    if (bus.cursor !== 3'd0 || bus.preset !== 32'h00F00F05) begin
      failures++; $display("FAIL alarm_keeps_state: cursor=%0d preset=%h expected 0 and %h", bus.cursor, bus.preset, 32'h00F00F05);
    end
    press(B_UP);
    checks++;
    if (bus.preset !== 32'h00F00F06) begin failures++; $display("FAIL edit_after_alarm: got %h expected %h", bus.preset, 32'h00F00F06); end
    press(B_DOWN);
  endtask

  task automatic test_back_to_back;
    press(B_START);
    checks++;
    if (bus.go !== 1'b1) begin failures++; $display("FAIL run_entry: go=%b expected 1", bus.go); end
    press(B_UP);
    checks++;
    if (bus.preset !== 32'h00F00F05 || bus.go !== 1'b1) begin
      failures++; $display("FAIL run_ignores_edit: preset=%h go=%b expected %h go=1", bus.preset, bus.go, 32'h00F00F05);
    end
    press_mask(5'b11000, 10);
    checks++;
    if ({bus.go, bus.alarm} !== 2'b00 || bus.preset !== 32'h00F00F05) begin
      failures++; $display("FAIL abort_start_over_up: go=%b alarm=%b preset=%h expected 0 0 %h", bus.go, bus.alarm, bus.preset, 32'h00F00F05);
    end
    press(B_START);
    tb_finish = 1'b1;
    repeat (3) @(negedge clk);
    tb_finish = 1'b0;
    checks++;
    if (bus.alarm !== 1'b1) begin failures++; $display("FAIL alarm_entry_2: got %b expected 1", bus.alarm); end
    tb_btn[B_LEFT] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.alarm !== 1'b1) begin failures++; $display("FAIL alarm_ack_early: got %b expected 1", bus.alarm); end
    @(negedge clk);
    checks++;
    if (bus.alarm !== 1'b0 || bus.go !== 1'b0) begin failures++; $display("FAIL alarm_ack_button: alarm=%b go=%b expected 0 0", bus.alarm, bus.go); end
    repeat (3) @(negedge clk);
    tb_btn = 5'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.cursor !== 3'd0) begin failures++; $display("FAIL ack_not_cursor_move: got %0d expected 0", bus.cursor); end
  endtask

  task automatic test_async_reset;
    press(B_START);
    checks++;
    if (bus.go !== 1'b1) begin failures++; $display("FAIL run_before_reset: go=%b expected 1", bus.go); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.go !== 1'b0 || bus.preset !== 32'h00F01F00) begin
      failures++; $display("FAIL async_reset: go=%b preset=%h expected 0 %h", bus.go, bus.preset, 32'h00F01F00);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    tb_btn    = 5'b0;
    tb_finish = 1'b0;
    @(negedge clk);
    test_reset;
    test_blink;
    test_debounce;
    test_edit_cursor;
    test_start_zero;
    test_finish_alarm;
    test_back_to_back;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
